// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package data_mem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index of a requesting port: 0 = CPU, 1 = DMA.
  typedef logic port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// port that was not served last.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output logic [1:0] gnt,
  output port_idx_t  winner
);

  // Pick the winner and expand it to a one-hot grant.
  always_comb begin
    winner = PORT0;
    gnt    = 2'b00;
    unique case (req)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      2'b11:   winner = ~last;
      default: winner = PORT0;
    endcase
    if (|req) gnt = 2'b01 << winner;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (port 0) and DMA (port 1) accesses onto a single data
// memory. Each access walks IDLE -> ACCESS -> RESP; misaligned addresses
// never reach memory and are flagged with err alongside the ack.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state_q,  state_d;
  port_idx_t         last_q,   last_d;
  port_idx_t         win_q,    win_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] gnt;
  port_idx_t  winner;
  logic       misaligned;

  assign misaligned = |addr_q[1:0];

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (last_q),
    .gnt    (gnt),
    .winner (winner)
  );

  // Next-state logic: grant and latch in IDLE, capture read data leaving ACCESS.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ACCESS;
          win_d   = winner;
          last_d  = winner;
          we_d    = gnt[1] ? we1    : we0;
          addr_d  = gnt[1] ? addr1  : addr0;
          wdata_d = gnt[1] ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q && !misaligned) begin
          if (win_q == PORT1) rdata1_d = mem_dout;
          else                rdata0_d = mem_dout;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes and response flags, decoded from the current state only.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_din   = wdata_q;
      mem_write = we_q && !misaligned;
      mem_read  = !we_q && !misaligned;
    end
    ack0 = (state_q == RESP) && (win_q == PORT0);
    ack1 = (state_q == RESP) && (win_q == PORT1);
    err0 = ack0 && misaligned;
    err1 = ack1 && misaligned;
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= PORT1;
      win_q    <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small word memory.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_read, mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  // Word-addressed memory model; preload port is used once during reset.
  logic [31:0] mem [0:1023];
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_val;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en)   mem[load_idx]       <= load_val;
    if (mem_write) mem[mem_addr[11:2]] <= mem_din;
  end

  assign mem_dout = mem_read ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  data_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_dout  (mem_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mem_quiet(input string tag);
    check({tag, "_mem_read"},  {31'd0, mem_read},  32'd0);
    check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, "_mem_addr"},  mem_addr,           32'd0);
    check({tag, "_mem_din"},   mem_din,            32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    load_en = 1'b1; load_idx = 10'd500; load_val = 32'h0000_1234;
    tick();
    load_en = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_err1", {31'd0, err1}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check_mem_quiet("rst");

    // Single read, port 0, addr 2000 -> 0x1234
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2000;
    check("rd_idle_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    check("rd_acc_mem_read",  {31'd0, mem_read},  32'd1);
    check("rd_acc_mem_write", {31'd0, mem_write}, 32'd0);
    check("rd_acc_mem_addr",  mem_addr,           32'd2000);
    check("rd_acc_ack0",      {31'd0, ack0},      32'd0);
    tick();
    check("rd_resp_ack0",     {31'd0, ack0},      32'd1);
    check("rd_resp_ack1",     {31'd0, ack1},      32'd0);
    check("rd_resp_err0",     {31'd0, err0},      32'd0);
    check("rd_resp_rdata0",   rdata0,             32'h0000_1234);
    check_mem_quiet("rd_resp");
    req0 = 1'b0;
    tick();
    check("rd_after_ack0",    {31'd0, ack0},      32'd0);
    check("rd_after_rdata0",  rdata0,             32'h0000_1234);

    // Single write, port 1, addr 2004 <- 0xCAFE
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd2004; wdata1 = 32'h0000_CAFE;
    tick();
    check("wr_acc_mem_write", {31'd0, mem_write}, 32'd1);
    check("wr_acc_mem_read",  {31'd0, mem_read},  32'd0);
    check("wr_acc_mem_addr",  mem_addr,           32'd2004);
    check("wr_acc_mem_din",   mem_din,            32'h0000_CAFE);
    tick();
    check("wr_resp_ack1",     {31'd0, ack1},      32'd1);
    check("wr_resp_ack0",     {31'd0, ack0},      32'd0);
    check("wr_resp_err1",     {31'd0, err1},      32'd0);
    check("wr_resp_mem_write", {31'd0, mem_write}, 32'd0);
    check("wr_mem_word",      mem[501],           32'h0000_CAFE);
    req1 = 1'b0; we1 = 1'b0;
    tick();

    // Read back 2004 on port 1; port 0 rdata must hold
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2004;
    tick();
    check("rb_acc_mem_read",  {31'd0, mem_read},  32'd1);
    tick();
    check("rb_resp_ack1",     {31'd0, ack1},      32'd1);
    check("rb_resp_rdata1",   rdata1,             32'h0000_CAFE);
    check("rb_resp_rdata0",   rdata0,             32'h0000_1234);
    req1 = 1'b0;
    tick();

    // Misaligned write, port 0, addr 2002
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd2002; wdata0 = 32'h0000_0BAD;
    tick();
    check("mis_acc_mem_write", {31'd0, mem_write}, 32'd0);
    check("mis_acc_mem_read",  {31'd0, mem_read},  32'd0);
    check("mis_acc_mem_addr",  mem_addr,           32'd2002);
    tick();
    check("mis_resp_ack0",     {31'd0, ack0},      32'd1);
    check("mis_resp_err0",     {31'd0, err0},      32'd1);
    check("mis_resp_mem_write", {31'd0, mem_write}, 32'd0);
    check("mis_mem_word",      mem[500],           32'h0000_1234);
    req0 = 1'b0; we0 = 1'b0;
    tick();

    // Misaligned read, port 1, addr 2001: rdata1 unchanged
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2001;
    tick();
    check("misr_acc_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    check("misr_resp_ack1",   {31'd0, ack1},      32'd1);
    check("misr_resp_err1",   {31'd0, err1},      32'd1);
    check("misr_resp_rdata1", rdata1,             32'h0000_CAFE);
    req1 = 1'b0;
    tick();

    // Contention from reset: grants alternate 0,1,0,1, acks 3 cycles apart
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2004;
    tick();
    rst = 1'b0;
    check("ct_rst_rdata0", rdata0, 32'd0);
    check("ct_rst_rdata1", rdata1, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("ct_ack0_c%0d", k), {31'd0, ack0}, {31'd0, (k % 6) == 2});
      check($sformatf("ct_ack1_c%0d", k), {31'd0, ack1}, {31'd0, (k % 6) == 5});
      if (k == 2) check("ct_rdata0", rdata0, 32'h0000_1234);
      if (k == 5) check("ct_rdata1", rdata1, 32'h0000_CAFE);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("ct_end_ack0", {31'd0, ack0}, 32'd0);
    check_mem_quiet("ct_end");

    // Reset during ACCESS of a write to 2008
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd2008; wdata0 = 32'h5555_AAAA;
    tick();
    check("ra_acc_mem_write", {31'd0, mem_write}, 32'd1);
    check("ra_acc_mem_addr",  mem_addr,           32'd2008);
    rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b0; we0 = 1'b0;
    check("ra_mem_word", mem[502], 32'h5555_AAAA);
    check("ra_ack0", {31'd0, ack0}, 32'd0);
    check("ra_ack1", {31'd0, ack1}, 32'd0);
    check_mem_quiet("ra_post");
    tick();
    check("ra_next_ack0", {31'd0, ack0}, 32'd0);
    check_mem_quiet("ra_next");

    // FSM restarted cleanly: read 2008 back
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2008;
    tick();
    check("ra_rb_mem_read", {31'd0, mem_read}, 32'd1);
    tick();
    check("ra_rb_ack0",   {31'd0, ack0}, 32'd1);
    check("ra_rb_rdata0", rdata0,        32'h5555_AAAA);
    req0 = 1'b0;
    tick();

    // Reset during RESP: ack visible that cycle, then gone
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2000;
    tick();
    tick();
    check("rr_resp_ack1",   {31'd0, ack1}, 32'd1);
    check("rr_resp_rdata1", rdata1,        32'h0000_1234);
    rst = 1'b1; req1 = 1'b0;
    tick();
    rst = 1'b0;
    check("rr_post_ack1",   {31'd0, ack1}, 32'd0);
    check("rr_post_rdata1", rdata1,        32'd0);
    check("rr_post_rdata0", rdata0,        32'd0);

    // Idle quiet for 20 cycles
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("iq_mem_read_c%0d", k),  {31'd0, mem_read},  32'd0);
      check($sformatf("iq_mem_write_c%0d", k), {31'd0, mem_write}, 32'd0);
      check($sformatf("iq_ack0_c%0d", k),      {31'd0, ack0},      32'd0);
      check($sformatf("iq_ack1_c%0d", k),      {31'd0, ack1},      32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
